rand_pkt_gen: RTL and testbench



---
 rtl/rand_pkt_gen.sv | 162 ++++++++++++++++
 tb/tb_rand_pkt_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rand_pkt_gen.sv
// rand_pkt_gen: random packet traffic generator fed by a free-running LFSR word.
// Each cycle, rand_vect supplies an inject byte, a packet length and a beat payload.
// The generator drives a valid/ready stream of packets for the downstream block.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   rand_vect        random bits, new value every cycle
//   start            one-cycle pulse, launches a run from IDLE or DONE
//   num_pkts         packets to send in the run (sampled on start)
//   inj_rate         injection threshold: 0 never, 256 always
//   stop             level; ends the run at the next packet boundary
//   out_valid/ready  beat handshake
//   out_data         beat payload
//   out_first/last   packet delimiters
//   out_pkt_id       index of current packet in the run
//   pkt_count        packets completed in the run
//   done             high while in DONE
module rand_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 3,
    parameter int CNT_WIDTH  = 16,
    parameter int RAND_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RAND_WIDTH-1:0] rand_vect,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_pkts,
    input  logic [8:0]            inj_rate,
    input  logic                  stop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  out_pkt_id,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  done
);

    if (RAND_WIDTH < DATA_WIDTH + 16) begin : g_width_check
        $error("rand_pkt_gen: RAND_WIDTH must be >= DATA_WIDTH+16");
    end

    typedef enum logic [1:0] {IDLE, ARB, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]  out_pkt_id_q, out_pkt_id_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  target_q, target_d;
    logic [LEN_BITS:0]     beats_left_q, beats_left_d;

    // Random fields of the current cycle
    logic [7:0]            inj_byte;
    logic [LEN_BITS:0]     pkt_len;
    logic [DATA_WIDTH-1:0] payload;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  unused_rand;

    assign inj_byte    = rand_vect[7:0];
    assign pkt_len     = {1'b0, rand_vect[8 +: LEN_BITS]} + 1'b1;
    assign payload     = rand_vect[16 +: DATA_WIDTH];
    assign count_inc   = pkt_count_q + 1'b1;
    assign unused_rand = ^rand_vect;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        out_pkt_id_d = out_pkt_id_q;
        pkt_count_d  = pkt_count_q;
        target_d     = target_q;
        beats_left_d = beats_left_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pkt_count_d  = '0;
                    out_pkt_id_d = '0;
                    target_d     = num_pkts;
                    state_d      = (num_pkts != '0) ? ARB : DONE;
                end
            end
            ARB: begin
                if (stop) begin
                    state_d = DONE;
                end else if ({1'b0, inj_byte} < inj_rate) begin
                    state_d      = SEND;
                    out_valid_d  = 1'b1;
                    out_first_d  = 1'b1;
                    out_data_d   = payload;
                    out_last_d   = (pkt_len == 1);
                    beats_left_d = pkt_len;
                end
            end
            SEND: begin
                // Without ready, everything holds (defaults).
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_first_d  = 1'b0;
                        out_last_d   = 1'b0;
                        pkt_count_d  = count_inc;
                        out_pkt_id_d = out_pkt_id_q + 1'b1;
                        // Leaving on reaching the target keeps pkt_count from wrapping.
                        state_d      = (count_inc == target_q) ? DONE : ARB;
                    end else begin
                        out_first_d  = 1'b0;
                        out_data_d   = payload;
                        beats_left_d = beats_left_q - 1'b1;
                        out_last_d   = (beats_left_q == 2);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_pkt_id_q <= '0;
            pkt_count_q  <= '0;
            done_q       <= 1'b0;
            target_q     <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            out_pkt_id_q <= out_pkt_id_d;
            pkt_count_q  <= pkt_count_d;
            done_q       <= done_d;
            target_q     <= target_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign out_pkt_id = out_pkt_id_q;
    assign pkt_count  = pkt_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rand_pkt_gen.sv
// Directed bench for rand_pkt_gen: drives rand_vect directly and checks each step
// against hand-computed expectations.
module tb_rand_pkt_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] rand_vect;
    logic        start;
    logic [15:0] num_pkts;
    logic [8:0]  inj_rate;
    logic        stop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [15:0] out_pkt_id;
    logic [15:0] pkt_count;
    logic        done;

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    rand_pkt_gen dut (
        .clk        (clk),
        .reset      (reset),
        .rand_vect  (rand_vect),
        .start      (start),
        .num_pkts   (num_pkts),
        .inj_rate   (inj_rate),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_pkt_id (out_pkt_id),
        .pkt_count  (pkt_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Accepted-beat counter
    always @(posedge clk) if (!reset && out_valid && out_ready) acc <= acc + 1;

    function automatic logic [47:0] mk(input logic [31:0] pl, input logic [2:0] len, input logic [7:0] r);
        return {pl, 5'b0, len, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks {valid, first, last}, data and pkt id of the presented beat
    task automatic chk_beat(input string tag, input logic [2:0] vfl, input logic [31:0] d, input logic [15:0] id);
        chk({tag, ".vfl"}, {29'b0, out_valid, out_first, out_last}, {29'b0, vfl});
        if (vfl[2]) begin
            chk({tag, ".data"}, out_data, d);
            chk({tag, ".id"}, {16'b0, out_pkt_id}, {16'b0, id});
        end
    endtask

    initial begin
        reset = 1'b1; rand_vect = '0; start = 0; num_pkts = 0; inj_rate = 0; stop = 0; out_ready = 1;
        tick(); tick();
        chk("rst.valid", {31'b0, out_valid}, 0);
        chk("rst.done", {31'b0, done}, 0);
        chk("rst.count", {16'b0, pkt_count}, 0);
        chk("rst.data", out_data, 0);
        reset = 1'b0;
        tick();

        // Single packet, length 3
        inj_rate = 9'd256; num_pkts = 1; start = 1; rand_vect = mk(32'hA5A5A5A5, 3'd2, 8'h00);
        tick(); start = 0;
        chk("single.arb", {31'b0, out_valid}, 0);
        tick();
        chk_beat("single.b0", 3'b110, 32'hA5A5A5A5, 0);
        rand_vect = mk(32'h1, 3'd2, 8'h00);
        tick(); chk_beat("single.b1", 3'b100, 32'h1, 0);
        tick(); chk_beat("single.b2", 3'b101, 32'h1, 0);
        tick();
        chk("single.done", {31'b0, done}, 1);
        chk("single.count", {16'b0, pkt_count}, 1);
        chk("single.valid_off", {31'b0, out_valid}, 0);

        // Backpressure on beat 1
        acc = 0;
        start = 1; rand_vect = mk(32'hA5A5A5A5, 3'd2, 8'h00);
        tick(); start = 0;
        chk("bp.restart_done", {31'b0, done}, 0);
        chk("bp.restart_count", {16'b0, pkt_count}, 0);
        tick(); chk_beat("bp.b0", 3'b110, 32'hA5A5A5A5, 0);
        rand_vect = mk(32'h1, 3'd2, 8'h00);
        tick(); chk_beat("bp.b1", 3'b100, 32'h1, 0);
        out_ready = 0; rand_vect = mk(32'hDEADBEEF, 3'd7, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_beat("bp.hold", 3'b100, 32'h1, 0);
        end
        out_ready = 1; rand_vect = mk(32'h1, 3'd2, 8'h00);
        tick(); chk_beat("bp.b2", 3'b101, 32'h1, 0);
        tick();
        chk("bp.done", {31'b0, done}, 1);
        chk("bp.accepted", acc, 3);

        // Injection gating at threshold
        inj_rate = 9'h10; start = 1; rand_vect = mk(32'h55, 3'd0, 8'h10);
        tick(); start = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); chk("gate.novalid", {31'b0, out_valid}, 0);
        end
        rand_vect = mk(32'h77, 3'd0, 8'h0F);
        tick(); chk_beat("gate.send", 3'b111, 32'h77, 0);
        tick(); chk("gate.done", {31'b0, done}, 1);

        // Stop asserted mid packet 2 (length-2 packets)
        inj_rate = 9'd256; num_pkts = 10; start = 1; rand_vect = mk(32'h100, 3'd1, 8'h00);
        tick(); start = 0;
        tick(); chk_beat("stop.p0b0", 3'b110, 32'h100, 0);
        tick(); chk_beat("stop.p0b1", 3'b101, 32'h100, 0);
        tick(); chk("stop.gap0", {31'b0, out_valid}, 0);
        tick(); chk_beat("stop.p1b0", 3'b110, 32'h100, 1);
        tick(); chk_beat("stop.p1b1", 3'b101, 32'h100, 1);
        tick(); chk("stop.count2", {16'b0, pkt_count}, 2);
        tick(); chk_beat("stop.p2b0", 3'b110, 32'h100, 2);
        stop = 1;
        tick(); chk_beat("stop.p2b1", 3'b101, 32'h100, 2);
        tick();
        chk("stop.valid_off", {31'b0, out_valid}, 0);
        chk("stop.count3", {16'b0, pkt_count}, 3);
        tick();
        chk("stop.done", {31'b0, done}, 1);
        chk("stop.count_hold", {16'b0, pkt_count}, 3);
        chk("stop.novalid", {31'b0, out_valid}, 0);
        stop = 0;

        // Reset on beat 1 of a length-4 packet
        num_pkts = 1; start = 1; rand_vect = mk(32'hABC, 3'd3, 8'h00);
        tick(); start = 0;
        tick(); chk_beat("rstmid.b0", 3'b110, 32'hABC, 0);
        tick(); chk_beat("rstmid.b1", 3'b100, 32'hABC, 0);
        #1 reset = 1; #1;
        chk("rstmid.valid", {31'b0, out_valid}, 0);
        chk("rstmid.data", out_data, 0);
        chk("rstmid.first", {31'b0, out_first}, 0);
        tick(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid.idle_valid", {31'b0, out_valid}, 0);
            chk("rstmid.idle_done", {31'b0, done}, 0);
        end

        // Zero-length run, then relaunch with 2 single-beat packets
        num_pkts = 0; start = 1;
        tick(); start = 0;
        chk("zero.done", {31'b0, done}, 1);
        chk("zero.count", {16'b0, pkt_count}, 0);
        num_pkts = 2; start = 1; rand_vect = mk(32'h5, 3'd0, 8'h00);
        tick(); start = 0;
        chk("relaunch.done_low", {31'b0, done}, 0);
        tick(); chk_beat("relaunch.p0", 3'b111, 32'h5, 0);
        tick(); chk("relaunch.count1", {16'b0, pkt_count}, 1);
        tick(); chk_beat("relaunch.p1", 3'b111, 32'h5, 1);
        tick();
        chk("relaunch.done", {31'b0, done}, 1);
        chk("relaunch.count2", {16'b0, pkt_count}, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
